load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multicycle memory-access sequencer for the MIPS datapath.
- Sits directly upstream of the MDR, which feeds the write-back data mux.
- Performs word, halfword and byte loads with sign or zero extension, and word, halfword and byte stores against a word-addressed, little-endian data memory.
- Sub-word stores are done as read-modify-write.
- Drives a 1-cycle done pulse to the control FSM.

Parameters:
- MEM_LATENCY, 1: cycles from presenting mem_addr (mem_wr=0) to mem_rdata being valid; legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe; sampled only in IDLE
- op  in  3  access type (lsu_op_t): LW, LH, LHU, LB, LBU, SW, SH, SB
- addr  in  32  byte address
- store_data  in  32  register rt value; low byte/half used for SB/SH
- mem_addr  out  32  word address to memory; addr with bits [1:0] forced to 0
- mem_wr  out  1  memory write enable
- mem_wdata  out  32  word written to memory
- mem_rdata  in  32  memory read data
- load_data  out  32  extended load result, to MDR
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle completion pulse
- misaligned  out  1  valid with done; access aborted

Behaviour:
- Reset values: all outputs 0, state IDLE, captured operands 0.
- Reset mid-operation: state returns to IDLE at the next edge and mem_wr deasserts at that edge. A write already issued in an earlier cycle is not undone. No done pulse is produced.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On start, capture op, addr and store_data.
  - If misaligned, go to DONE with misaligned=1. Misaligned means: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]=1.
  - Else if SW, go to WRITE.
  - Else go to READ and load the latency counter with MEM_LATENCY-1.
- READ:
  - mem_addr valid, mem_wr=0.
  - Counter decrements each cycle; at 0, capture mem_rdata into the internal rdata register.
  - Next state: loads go to DONE; SH/SB go to WRITE.
- WRITE: mem_wr=1 for exactly one cycle, then DONE. mem_wdata depends on op:
  - SW: store_data.
  - SH: rdata with half addr[1] (bits [16*addr[1]+15 : 16*addr[1]]) replaced by store_data[15:0].
  - SB: rdata with byte addr[1:0] replaced by store_data[7:0].
- DONE:
  - done=1 for one cycle, then IDLE.
  - For loads, load_data updates on entry to DONE and holds until the next load completes.
  - Stores and misaligned accesses leave load_data unchanged.
- Load extraction: select byte or half by addr[1:0] / addr[1]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- Latency in cycles after the start cycle, with L = MEM_LATENCY:
  - load: L+1
  - SW: 2
  - SH/SB: L+2
  - misaligned: 1
- Back-to-back: start asserted during DONE is ignored; the earliest new accept is the cycle after done.
- start while busy is ignored and not queued.
- Undefined op encodings are treated as LW.
- mem_addr holds its value outside READ/WRITE; mem_wr is 0 outside WRITE.

Decomposition:
- Package lsu_pkg: lsu_op_t enum (3 bits), lsu_state_t enum, helper function is_store().
- Sub-module lsu_align, combinational:
  - Extraction path: inputs rdata, addr[1:0], op; output extended load word.
  - Merge path: inputs rdata, store_data, addr[1:0], op; output store word.
- The top level holds the FSM, latency counter and operand registers.

Test Plan:
1. MEM_LATENCY=1; memory word 0x80 = 0x8899AABB; LB addr 0x81 -> done on cycle 2, load_data=0xFFFFFFAA, no mem_wr.
2. Same word; LHU addr 0x82 -> load_data=0x00008899; LH addr 0x82 -> 0xFFFF8899.
3. Word 0x40 = 0x11223344; SB addr 0x43 with store_data=0xDEADBEEF -> one READ cycle, then mem_wr=1 with mem_wdata=0xEF223344 and mem_addr=0x40; done on cycle 3.
4. SW addr 0x10 with data 0xCAFEF00D -> mem_wr asserted on cycle 1 only, with no preceding read; done on cycle 2.
5. LW addr 0x06 and SH addr 0x0B -> done on cycle 1 with misaligned=1, mem_wr never asserted, load_data unchanged.
6. MEM_LATENCY=3 SH in progress; assert reset in the second READ cycle -> IDLE next edge, mem_wr never asserted, busy=0, done=0. Then LW issued 1 cycle later completes normally in 4 cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit.
//   lsu_op_t      - 3-bit access type; all eight encodings are defined.
//   lsu_state_t   - sequencer states.
//   is_store()    - true for SW/SH/SB.
//   is_misaligned - alignment check for an op and the low address bits.
package lsu_pkg;

   typedef enum logic [2:0] {
      LW  = 3'd0,
      LH  = 3'd1,
      LHU = 3'd2,
      LB  = 3'd3,
      LBU = 3'd4,
      SW  = 3'd5,
      SH  = 3'd6,
      SB  = 3'd7
   } lsu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } lsu_state_t;

   function automatic logic is_store(input lsu_op_t op);
      return (op == SW) || (op == SH) || (op == SB);
   endfunction

   // Words need both low bits clear, halves need bit 0 clear, bytes never fault.
   function automatic logic is_misaligned(input lsu_op_t op, input logic [1:0] lo);
      case (op)
         LW, SW:      return lo != 2'b00;
         LH, LHU, SH: return lo[0];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for a little-endian word memory.
//   rdata      in  32  memory word (read data or captured read-modify-write word)
//   store_data in  32  register value to store
//   byte_sel   in  2   addr[1:0] of the access
//   op         in  3   access type
//   load_word  out 32  selected byte/half, sign- or zero-extended; LW passes through
//   store_word out 32  word to write: store_data for SW, merged word for SH/SB
module lsu_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [31:0] store_data,
   input  logic [1:0]  byte_sel,
   input  lsu_op_t     op,
   output logic [31:0] load_word,
   output logic [31:0] store_word
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      case (byte_sel)
         2'd0:    sel_byte = rdata[7:0];
         2'd1:    sel_byte = rdata[15:8];
         2'd2:    sel_byte = rdata[23:16];
         default: sel_byte = rdata[31:24];
      endcase
      sel_half = byte_sel[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (op)
         LB:      load_word = {{24{sel_byte[7]}}, sel_byte};
         LBU:     load_word = {24'd0, sel_byte};
         LH:      load_word = {{16{sel_half[15]}}, sel_half};
         LHU:     load_word = {16'd0, sel_half};
         default: load_word = rdata;
      endcase
   end

   always_comb begin
      store_word = rdata;
      case (op)
         SH: begin
            if (byte_sel[1]) store_word[31:16] = store_data[15:0];
            else             store_word[15:0]  = store_data[15:0];
         end
         SB: begin
            case (byte_sel)
               2'd0:    store_word[7:0]   = store_data[7:0];
               2'd1:    store_word[15:8]  = store_data[7:0];
               2'd2:    store_word[23:16] = store_data[7:0];
               default: store_word[31:24] = store_data[7:0];
            endcase
         end
         default: store_word = store_data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multicycle memory-access sequencer feeding the MDR.
//   clk, reset        system clock, synchronous active-high reset
//   start/op/addr/store_data  request, sampled only in IDLE
//   mem_addr/mem_wr/mem_wdata/mem_rdata  word-addressed data memory port
//   load_data         extended load result, held until the next load completes
//   busy              high outside IDLE
//   done              1-cycle completion pulse
//   misaligned        qualifies done; the access was aborted
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  lsu_op_t     op,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        busy,
   output logic        done,
   output logic        misaligned
);

   localparam logic [1:0] CNT_INIT = 2'(MEM_LATENCY - 1);

   lsu_state_t  state, state_nxt;
   lsu_op_t     op_r;
   logic [1:0]  addr_lo;
   logic [31:0] sdata_r;
   logic [31:0] rdata_r;
   logic [1:0]  cnt;
   logic        mis_r;
   logic        bad;
   logic [31:0] align_rdata;
   logic [31:0] ext_word;
   logic [31:0] merge_word;

   assign bad = is_misaligned(op, addr[1:0]);

   // In READ the extractor works on live memory data so load_data can be
   // written on the same edge that enters DONE; in WRITE it merges into the
   // word captured at the end of READ.
   assign align_rdata = (state == ST_READ) ? mem_rdata : rdata_r;

   lsu_align u_align (
      .rdata      (align_rdata),
      .store_data (sdata_r),
      .byte_sel   (addr_lo),
      .op         (op_r),
      .load_word  (ext_word),
      .store_word (merge_word)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (bad)           state_nxt = ST_DONE;
               else if (op == SW) state_nxt = ST_WRITE;
               else               state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (cnt == 2'd0) state_nxt = is_store(op_r) ? ST_WRITE : ST_DONE;
         end
         ST_WRITE: state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_r      <= LW;
         addr_lo   <= 2'd0;
         sdata_r   <= 32'd0;
         rdata_r   <= 32'd0;
         cnt       <= 2'd0;
         mis_r     <= 1'b0;
         mem_addr  <= 32'd0;
         load_data <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_r    <= op;
                  addr_lo <= addr[1:0];
                  sdata_r <= store_data;
                  mis_r   <= bad;
                  cnt     <= CNT_INIT;
                  // A misaligned request never reaches memory, so the bus address is left alone.
                  if (!bad) mem_addr <= {addr[31:2], 2'b00};
               end
            end
            ST_READ: begin
               if (cnt == 2'd0) begin
                  rdata_r <= mem_rdata;
                  if (!is_store(op_r)) load_data <= ext_word;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_wr     = (state == ST_WRITE);
   assign mem_wdata  = merge_word;
   assign busy       = (state != ST_IDLE);
   assign done       = (state == ST_DONE);
   assign misaligned = (state == ST_DONE) && mis_r;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   import lsu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   int          checks = 0;
   int          failures = 0;

   // DUT with MEM_LATENCY=1
   logic        start1;
   lsu_op_t     op1;
   logic [31:0] addr1, sd1, mem_addr1, mem_wdata1, mem_rdata1, load_data1;
   logic        mem_wr1, busy1, done1, misaligned1;

   // DUT with MEM_LATENCY=3
   logic        start3;
   lsu_op_t     op3;
   logic [31:0] addr3, sd3, mem_addr3, mem_wdata3, mem_rdata3, load_data3;
   logic        mem_wr3, busy3, done3, misaligned3;

   logic [31:0] mem1 [0:63];
   logic [31:0] mem3 [0:63];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [31:0] pre_data;

   load_store_unit #(.MEM_LATENCY(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .op(op1), .addr(addr1),
      .store_data(sd1), .mem_addr(mem_addr1), .mem_wr(mem_wr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .load_data(load_data1),
      .busy(busy1), .done(done1), .misaligned(misaligned1)
   );

   load_store_unit #(.MEM_LATENCY(3)) u3 (
      .clk(clk), .reset(reset), .start(start3), .op(op3), .addr(addr3),
      .store_data(sd3), .mem_addr(mem_addr3), .mem_wr(mem_wr3),
      .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .load_data(load_data3),
      .busy(busy3), .done(done3), .misaligned(misaligned3)
   );

   assign mem_rdata1 = mem1[mem_addr1[7:2]];
   assign mem_rdata3 = mem3[mem_addr3[7:2]];

   always @(posedge clk) begin
      if (pre_we) mem1[pre_idx] <= pre_data;
      else if (mem_wr1) mem1[mem_addr1[7:2]] <= mem_wdata1;
   end

   always @(posedge clk) begin
      if (pre_we) mem3[pre_idx] <= pre_data;
      else if (mem_wr3) mem3[mem_addr3[7:2]] <= mem_wdata3;
   end

   task automatic preload(input logic [5:0] idx, input logic [31:0] d);
      pre_we = 1'b1; pre_idx = idx; pre_data = d;
      @(posedge clk); #1;
      pre_we = 1'b0;
   endtask

   // Issue one request on u1 and follow it to done (bounded).
   task automatic run1(input lsu_op_t o, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output int wrs, output int rds,
                       output logic [31:0] wa, output logic [31:0] wd, output logic mis);
      @(posedge clk); #1;
      start1 = 1'b1; op1 = o; addr1 = a; sd1 = d;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 1; wrs = 0; rds = 0; wa = 32'd0; wd = 32'd0; mis = 1'b0;
      while (!done1 && cyc < 20) begin
         if (mem_wr1) begin wrs++; wa = mem_addr1; wd = mem_wdata1; end
         else if (busy1) rds++;
         @(posedge clk); #1;
         cyc++;
      end
      if (done1) begin
         mis = misaligned1;
         if (mem_wr1) wrs++;
      end else cyc = 99;
   endtask

   task automatic run3(input lsu_op_t o, input logic [31:0] a, input logic [31:0] d,
                       output int cyc, output int wrs);
      @(posedge clk); #1;
      start3 = 1'b1; op3 = o; addr3 = a; sd3 = d;
      @(posedge clk); #1;
      start3 = 1'b0;
      cyc = 1; wrs = 0;
      while (!done3 && cyc < 20) begin
         if (mem_wr3) wrs++;
         @(posedge clk); #1;
         cyc++;
      end
      if (done3) begin
         if (mem_wr3) wrs++;
      end else cyc = 99;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy1); end
      checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done1); end
      checks++; if (mem_wr1 !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr1); end
      checks++; if (misaligned1 !== 1'b0) begin failures++; $display("FAIL reset_misaligned got=%b exp=0", misaligned1); end
      checks++; if (load_data1 !== 32'd0) begin failures++; $display("FAIL reset_load_data got=%h exp=0", load_data1); end
      checks++; if (mem_addr1 !== 32'd0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr1); end
      checks++; if (mem_wdata1 !== 32'd0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata1); end
      checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL reset_busy3 got=%b exp=0", busy3); end
      reset = 1'b0;
   endtask

   task automatic test_byte_load();
      int cyc, wrs, rds; logic [31:0] wa, wd; logic mis;
      preload(6'h20, 32'h8899AABB);
      run1(LB, 32'h81, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 2) begin failures++; $display("FAIL lb_latency got=%0d exp=2", cyc); end
      checks++; if (load_data1 !== 32'hFFFFFFAA) begin failures++; $display("FAIL lb_data got=%h exp=ffffffaa", load_data1); end
      checks++; if (wrs !== 0) begin failures++; $display("FAIL lb_no_write got=%0d exp=0", wrs); end
      checks++; if (mis !== 1'b0) begin failures++; $display("FAIL lb_misaligned got=%b exp=0", mis); end
      run1(LBU, 32'h83, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (load_data1 !== 32'h00000088) begin failures++; $display("FAIL lbu_data got=%h exp=00000088", load_data1); end
   endtask

   task automatic test_half_load();
      int cyc, wrs, rds; logic [31:0] wa, wd; logic mis;
      run1(LHU, 32'h82, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (load_data1 !== 32'h00008899) begin failures++; $display("FAIL lhu_data got=%h exp=00008899", load_data1); end
      run1(LH, 32'h82, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (load_data1 !== 32'hFFFF8899) begin failures++; $display("FAIL lh_hi_data got=%h exp=ffff8899", load_data1); end
      run1(LH, 32'h80, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (load_data1 !== 32'hFFFFAABB) begin failures++; $display("FAIL lh_lo_data got=%h exp=ffffaabb", load_data1); end
      run1(LW, 32'h80, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (load_data1 !== 32'h8899AABB) begin failures++; $display("FAIL lw_data got=%h exp=8899aabb", load_data1); end
      checks++; if (cyc !== 2) begin failures++; $display("FAIL lw_latency got=%0d exp=2", cyc); end
   endtask

   task automatic test_sub_store();
      int cyc, wrs, rds; logic [31:0] wa, wd; logic mis;
      preload(6'h10, 32'h11223344);
      run1(SB, 32'h43, 32'hDEADBEEF, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", cyc); end
      checks++; if (rds !== 1) begin failures++; $display("FAIL sb_read_cycles got=%0d exp=1", rds); end
      checks++; if (wrs !== 1) begin failures++; $display("FAIL sb_write_count got=%0d exp=1", wrs); end
      checks++; if (wa !== 32'h40) begin failures++; $display("FAIL sb_addr got=%h exp=00000040", wa); end
      checks++; if (wd !== 32'hEF223344) begin failures++; $display("FAIL sb_wdata got=%h exp=ef223344", wd); end
      checks++; if (mem1[16] !== 32'hEF223344) begin failures++; $display("FAIL sb_mem got=%h exp=ef223344", mem1[16]); end
      checks++; if (load_data1 !== 32'h8899AABB) begin failures++; $display("FAIL sb_load_hold got=%h exp=8899aabb", load_data1); end
      run1(SH, 32'h42, 32'h0000CAFE, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 3) begin failures++; $display("FAIL sh_latency got=%0d exp=3", cyc); end
      checks++; if (wd !== 32'hCAFE3344) begin failures++; $display("FAIL sh_wdata got=%h exp=cafe3344", wd); end
   endtask

   task automatic test_word_store();
      int cyc, wrs, rds; logic [31:0] wa, wd; logic mis;
      run1(SW, 32'h10, 32'hCAFEF00D, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", cyc); end
      checks++; if (rds !== 0) begin failures++; $display("FAIL sw_read_cycles got=%0d exp=0", rds); end
      checks++; if (wrs !== 1) begin failures++; $display("FAIL sw_write_count got=%0d exp=1", wrs); end
      checks++; if (wa !== 32'h10) begin failures++; $display("FAIL sw_addr got=%h exp=00000010", wa); end
      checks++; if (wd !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_wdata got=%h exp=cafef00d", wd); end
   endtask

   task automatic test_misaligned();
      int cyc, wrs, rds; logic [31:0] wa, wd; logic mis;
      run1(LW, 32'h06, 32'd0, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL mis_lw_latency got=%0d exp=1", cyc); end
      checks++; if (mis !== 1'b1) begin failures++; $display("FAIL mis_lw_flag got=%b exp=1", mis); end
      checks++; if (load_data1 !== 32'h8899AABB) begin failures++; $display("FAIL mis_lw_load_hold got=%h exp=8899aabb", load_data1); end
      run1(SH, 32'h0B, 32'h12345678, cyc, wrs, rds, wa, wd, mis);
      checks++; if (cyc !== 1) begin failures++; $display("FAIL mis_sh_latency got=%0d exp=1", cyc); end
      checks++; if (mis !== 1'b1) begin failures++; $display("FAIL mis_sh_flag got=%b exp=1", mis); end
      checks++; if (wrs !== 0) begin failures++; $display("FAIL mis_sh_no_write got=%0d exp=0", wrs); end
      checks++; if (mem_addr1 !== 32'h10) begin failures++; $display("FAIL mis_sh_addr_hold got=%h exp=00000010", mem_addr1); end
   endtask

   task automatic test_back_to_back();
      logic [6:1] pat;
      @(posedge clk); #1;
      start1 = 1'b1; op1 = LBU; addr1 = 32'h80; sd1 = 32'd0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         pat[c] = done1;
      end
      start1 = 1'b0;
      checks++; if (pat !== 6'b010010) begin failures++; $display("FAIL b2b_done_pattern got=%b exp=010010", pat); end
      checks++; if (load_data1 !== 32'h000000BB) begin failures++; $display("FAIL b2b_data got=%h exp=000000bb", load_data1); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", busy1); end
   endtask

   task automatic test_reset_mid_op();
      int cyc, wrs;
      int wr_seen;
      wr_seen = 0;
      preload(6'h08, 32'h01020304);
      preload(6'h09, 32'h5A5A1234);
      @(posedge clk); #1;
      start3 = 1'b1; op3 = SH; addr3 = 32'h20; sd3 = 32'h0000BEEF;
      @(posedge clk); #1;
      start3 = 1'b0;
      if (mem_wr3) wr_seen++;
      @(posedge clk); #1;
      if (mem_wr3) wr_seen++;
      checks++; if (busy3 !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy3); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy3); end
      checks++; if (done3 !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done3); end
      checks++; if (mem_wr3 !== 1'b0) begin failures++; $display("FAIL rst_mid_mem_wr got=%b exp=0", mem_wr3); end
      reset = 1'b0;
      checks++; if (wr_seen !== 0) begin failures++; $display("FAIL rst_mid_no_write got=%0d exp=0", wr_seen); end
      run3(LW, 32'h24, 32'd0, cyc, wrs);
      checks++; if (cyc !== 4) begin failures++; $display("FAIL rst_lw_latency got=%0d exp=4", cyc); end
      checks++; if (load_data3 !== 32'h5A5A1234) begin failures++; $display("FAIL rst_lw_data got=%h exp=5a5a1234", load_data3); end
      checks++; if (wrs !== 0) begin failures++; $display("FAIL rst_lw_no_write got=%0d exp=0", wrs); end
      checks++; if (mem3[8] !== 32'h01020304) begin failures++; $display("FAIL rst_mem_intact got=%h exp=01020304", mem3[8]); end
   endtask

   initial begin
      reset = 1'b1;
      start1 = 1'b0; op1 = LW; addr1 = 32'd0; sd1 = 32'd0;
      start3 = 1'b0; op3 = LW; addr3 = 32'd0; sd3 = 32'd0;
      pre_we = 1'b0; pre_idx = 6'd0; pre_data = 32'd0;
      test_reset();
      test_byte_load();
      test_half_load();
      test_sub_store();
      test_word_store();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
